// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU codes, mux selects, FSM states.
// The HALT state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [3:0] {
      FETCH1  = 4'd0,
      FETCH2  = 4'd1,
      FETCH3  = 4'd2,
      FETCH4  = 4'd3,
      DECODE  = 4'd4,
      MEMADR  = 4'd5,
      LBRD    = 4'd6,
      LBWR    = 4'd7,
      SBWR    = 4'd8,
      RTYPEEX = 4'd9,
      RTYPEWR = 4'd10,
      BEQEX   = 4'd11,
      JEX     = 4'd12,
      ADDIEX  = 4'd13,
`ifdef CTRL_ILLEGAL_TRAP_EN
      ADDIWR  = 4'd14,
      HALT    = 4'd15
`else
      ADDIWR  = 4'd14
`endif
   } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control: fixed add/sub from the FSM, or the R-type funct field.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucont
);

   always_comb begin
      alucont = ALU_ADD;
      case (aluop)
         ALUOP_SUB:   alucont = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: alucont = ALU_ADD;
               FUNCT_SUB: alucont = ALU_SUB;
               FUNCT_AND: alucont = ALU_AND;
               FUNCT_OR:  alucont = ALU_OR;
               FUNCT_SLT: alucont = ALU_SLT;
               default:   alucont = ALU_ADD;
            endcase
         end
         default:     alucont = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the 8-bit multicycle MIPS datapath (LB, SB, R-type, BEQ, J, ADDI).
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in a HALT state with a halted output.
module mips_multicycle_controller
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic [3:0] irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucont,
`ifdef CTRL_ILLEGAL_TRAP_EN
   output logic       halted,
`endif
   output logic [1:0] pcsource
);

   state_t     state;
   aluop_t     aluop;
   logic       pcwrite;
   logic       branch;
   logic [2:0] dec_alucont;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH1;
      else begin
         case (state)
            FETCH1:  state <= FETCH2;
            FETCH2:  state <= FETCH3;
            FETCH3:  state <= FETCH4;
            FETCH4:  state <= DECODE;
            DECODE: begin
               case (op)
                  OP_LB, OP_SB: state <= MEMADR;
                  OP_RTYPE:     state <= RTYPEEX;
                  OP_BEQ:       state <= BEQEX;
                  OP_J:         state <= JEX;
                  OP_ADDI:      state <= ADDIEX;
`ifdef CTRL_ILLEGAL_TRAP_EN
                  default:      state <= HALT;
`else
                  default:      state <= FETCH1;
`endif
               endcase
            end
            MEMADR:  state <= (op == OP_SB) ? SBWR : LBRD;
            LBRD:    state <= LBWR;
            RTYPEEX: state <= RTYPEWR;
            ADDIEX:  state <= ADDIWR;
`ifdef CTRL_ILLEGAL_TRAP_EN
            HALT:    state <= HALT;
`endif
            default: state <= FETCH1;
         endcase
      end
   end

   mips_alu_decoder u_alu_decoder (
      .aluop   (aluop),
      .funct   (funct),
      .alucont (dec_alucont)
   );

   always_comb begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 4'b0000;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = SRCB_B;
      pcsource = PCSRC_ALU;
      aluop    = ALUOP_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
      halted   = 1'b0;
`endif
      case (state)
         FETCH1, FETCH2, FETCH3, FETCH4: begin
            pcwrite = 1'b1;
            alusrcb = SRCB_ONE;
            irwrite = 4'b0001 << state[1:0];
         end
         // ALUOut captures PC + 4 + imm*4 here as the speculative branch target
         DECODE:  alusrcb = SRCB_IMM4;
         MEMADR, ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         // Memory address comes straight off the ALU, so its inputs stay steered
         LBRD: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            iord    = 1'b1;
         end
         SBWR: begin
            alusrca  = 1'b1;
            alusrcb  = SRCB_IMM;
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         LBWR: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         RTYPEWR: begin
            alusrca  = 1'b1;
            aluop    = ALUOP_FUNCT;
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         BEQEX: begin
            alusrca  = 1'b1;
            aluop    = ALUOP_SUB;
            pcsource = PCSRC_ALUOUT;
            branch   = 1'b1;
         end
         JEX: begin
            pcsource = PCSRC_JUMP;
            pcwrite  = 1'b1;
         end
         ADDIWR: begin
            alusrca  = 1'b1;
            alusrcb  = SRCB_IMM;
            regwrite = 1'b1;
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         HALT:    halted = 1'b1;
`endif
         default: ;
      endcase
      pcen = pcwrite | (branch & zero);
      if (reset) begin
         pcen     = 1'b0;
         iord     = 1'b0;
         memwrite = 1'b0;
         irwrite  = 4'b0000;
         regdst   = 1'b0;
         memtoreg = 1'b0;
         regwrite = 1'b0;
         alusrca  = 1'b0;
         alusrcb  = 2'b00;
         pcsource = 2'b00;
`ifdef CTRL_ILLEGAL_TRAP_EN
         halted   = 1'b0;
`endif
      end
   end

   assign alucont = reset ? 3'b000 : dec_alucont;

endmodule
